// File: rtl/wb_arbiter2_pkg.sv
// Shared types for the Wishbone instruction/data arbiter: state and master
// encodings, the request bundle, and the round-robin pick rule.
package wb_arbiter2_pkg;

    typedef enum logic [1:0] {
        WBA_IDLE  = 2'd0,
        WBA_GNT_I = 2'd1,
        WBA_GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        WB_M_INST = 1'b0,
        WB_M_DATA = 1'b1
    } master_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        we;
        logic        cyc;
        logic        stb;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '0;

    // On a tie the master that did not win last time is chosen.
    function automatic master_e rr_pick(input logic    inst_req,
                                        input logic    data_req,
                                        input master_e last);
        if (inst_req && data_req) begin
            return (last == WB_M_INST) ? WB_M_DATA : WB_M_INST;
        end else if (data_req) begin
            return WB_M_DATA;
        end
        return WB_M_INST;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Ack watchdog: counts cycles a strobe waits without being cleared and
// pulses fire for one cycle when the count reaches TIMEOUT (0 disables it).
module wb_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic fire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign fire = 1'b0;
        end else begin : g_on
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

            logic [CNT_W-1:0] count;

            // An ack in the limit cycle clears the count first, so no err.
            assign fire = run && !clr && (count == LIMIT);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (clr || !run || fire) begin
                    count <= '0;
                end else if (count != '1) begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter (instruction fetch vs data) in front of
// one RAM port: round-robin on ties, locked per cycle, with an ack watchdog.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    input  logic [3:0]  inst_sel,
    input  logic        inst_we,
    input  logic        inst_cyc,
    input  logic        inst_stb,
    output logic [31:0] inst_rdata,
    output logic        inst_ack,
    output logic        inst_err,
    output logic        inst_gnt,

    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_sel,
    input  logic        data_we,
    input  logic        data_cyc,
    input  logic        data_stb,
    output logic [31:0] data_rdata,
    output logic        data_ack,
    output logic        data_err,
    output logic        data_gnt,

    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_sel,
    output logic        ram_we,
    output logic        ram_cyc,
    output logic        ram_stb,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack
);

    arb_state_e state;
    master_e    last;
    wb_req_t    inst_req;
    wb_req_t    data_req;
    wb_req_t    ram_req;
    logic       inst_want;
    logic       data_want;
    logic       wd_clr;
    logic       wd_fire;

    assign inst_req  = '{inst_addr, inst_wdata, inst_sel, inst_we, inst_cyc, inst_stb};
    assign data_req  = '{data_addr, data_wdata, data_sel, data_we, data_cyc, data_stb};
    assign inst_want = inst_cyc && inst_stb;
    assign data_want = data_cyc && data_stb;

    // Grant FSM. The grant flags are registered copies of the state decode so
    // that async reset drops them together with the state.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WBA_IDLE;
            last     <= WB_M_DATA;
            inst_gnt <= 1'b0;
            data_gnt <= 1'b0;
        end else begin
            case (state)
                WBA_IDLE: begin
                    if (inst_want || data_want) begin
                        if (rr_pick(inst_want, data_want, last) == WB_M_INST) begin
                            state    <= WBA_GNT_I;
                            last     <= WB_M_INST;
                            inst_gnt <= 1'b1;
                        end else begin
                            state    <= WBA_GNT_D;
                            last     <= WB_M_DATA;
                            data_gnt <= 1'b1;
                        end
                    end
                end
                WBA_GNT_I: begin
                    if (!inst_cyc) begin
                        state    <= WBA_IDLE;
                        inst_gnt <= 1'b0;
                    end
                end
                WBA_GNT_D: begin
                    if (!data_cyc) begin
                        state    <= WBA_IDLE;
                        data_gnt <= 1'b0;
                    end
                end
                default: begin
                    state    <= WBA_IDLE;
                    inst_gnt <= 1'b0;
                    data_gnt <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the default assignment before the case keeps this purely
    // combinational; a path that leaves ram_req unassigned would infer a latch.
    always_comb begin
        ram_req = WB_REQ_IDLE;
        case (state)
            WBA_GNT_I: ram_req = inst_req;
            WBA_GNT_D: ram_req = data_req;
            default:   ram_req = WB_REQ_IDLE;
        endcase
    end

    assign ram_addr  = ram_req.addr;
    assign ram_wdata = ram_req.wdata;
    assign ram_sel   = ram_req.sel;
    assign ram_we    = ram_req.we;
    assign ram_cyc   = ram_req.cyc;
    assign ram_stb   = ram_req.stb;

    // Read data is broadcast; only the owner's ack qualifies it.
    assign inst_rdata = ram_rdata;
    assign data_rdata = ram_rdata;
    assign inst_ack   = ram_ack && inst_gnt;
    assign data_ack   = ram_ack && data_gnt;
    assign inst_err   = wd_fire && inst_gnt;
    assign data_err   = wd_fire && data_gnt;

    assign wd_clr = (state == WBA_IDLE) || ram_ack;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .run   (ram_req.stb),
        .fire  (wd_fire)
    );

    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(inst_gnt && data_gnt));

    a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        (state == WBA_IDLE) |-> !(ram_cyc || ram_stb || ram_we));

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios followed by random
// two-master traffic, all scored against a cycle-level ownership model.
module tb_wb_arbiter2;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_sel, data_sel;
    logic        inst_we, inst_cyc, inst_stb, data_we, data_cyc, data_stb;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_ack, inst_err, inst_gnt, data_ack, data_err, data_gnt;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;
    logic        ram_we, ram_cyc, ram_stb, ram_ack;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_addr  (inst_addr),
        .inst_wdata (inst_wdata),
        .inst_sel   (inst_sel),
        .inst_we    (inst_we),
        .inst_cyc   (inst_cyc),
        .inst_stb   (inst_stb),
        .inst_rdata (inst_rdata),
        .inst_ack   (inst_ack),
        .inst_err   (inst_err),
        .inst_gnt   (inst_gnt),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_sel   (data_sel),
        .data_we    (data_we),
        .data_cyc   (data_cyc),
        .data_stb   (data_stb),
        .data_rdata (data_rdata),
        .data_ack   (data_ack),
        .data_err   (data_err),
        .data_gnt   (data_gnt),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_sel    (ram_sel),
        .ram_we     (ram_we),
        .ram_cyc    (ram_cyc),
        .ram_stb    (ram_stb),
        .ram_rdata  (ram_rdata),
        .ram_ack    (ram_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the RAM port (-1 nobody, 0 inst, 1 data),
    // who won the last grant, and how long the current strobe has waited.
    int   m_owner;
    int   m_last;
    int   m_waited;
    logic m_stb_now;
    logic m_fire_now;
    logic e_ack_m [2];
    logic e_err_m [2];

    // Observed values from the latest compare, for directed checks.
    logic [1:0]  s_gnt, s_ack, s_err;
    logic [31:0] s_addr, s_wdata;
    logic [6:0]  s_ctl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_now();
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_sel;
        logic        e_we, e_cyc, e_stb, e_fire;
        e_addr = '0; e_wdata = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
        if (m_owner == 0) begin
            e_addr = inst_addr; e_wdata = inst_wdata; e_sel = inst_sel;
            e_we = inst_we; e_cyc = inst_cyc; e_stb = inst_stb;
        end else if (m_owner == 1) begin
            e_addr = data_addr; e_wdata = data_wdata; e_sel = data_sel;
            e_we = data_we; e_cyc = data_cyc; e_stb = data_stb;
        end
        e_fire = (m_owner >= 0) && e_stb && !ram_ack && (m_waited == TO);
        m_stb_now  = e_stb;
        m_fire_now = e_fire;
        e_ack_m[0] = ram_ack && (m_owner == 0);
        e_ack_m[1] = ram_ack && (m_owner == 1);
        e_err_m[0] = e_fire && (m_owner == 0);
        e_err_m[1] = e_fire && (m_owner == 1);

        check("grant", 64'({inst_gnt, data_gnt}), 64'({m_owner == 0, m_owner == 1}));
        check("ack", 64'({inst_ack, data_ack}), 64'({e_ack_m[0], e_ack_m[1]}));
        check("err", 64'({inst_err, data_err}), 64'({e_err_m[0], e_err_m[1]}));
        check("ram_addr", 64'(ram_addr), 64'(e_addr));
        check("ram_wdata", 64'(ram_wdata), 64'(e_wdata));
        check("ram_ctl", 64'({ram_sel, ram_we, ram_cyc, ram_stb}), 64'({e_sel, e_we, e_cyc, e_stb}));
        check("rdata", 64'({inst_rdata, data_rdata}), {ram_rdata, ram_rdata});

        s_gnt   = {inst_gnt, data_gnt};
        s_ack   = {inst_ack, data_ack};
        s_err   = {inst_err, data_err};
        s_addr  = ram_addr;
        s_wdata = ram_wdata;
        s_ctl   = {ram_sel, ram_we, ram_cyc, ram_stb};
    endtask

    task automatic model_update();
        logic ri, rd;
        if (m_owner < 0 || !m_stb_now || ram_ack || m_fire_now) m_waited = 0;
        else m_waited++;
        ri = inst_cyc && inst_stb;
        rd = data_cyc && data_stb;
        if (m_owner < 0) begin
            if (ri && rd) m_owner = (m_last == 1) ? 0 : 1;
            else if (ri)  m_owner = 0;
            else if (rd)  m_owner = 1;
            if (m_owner >= 0) m_last = m_owner;
        end else if (m_owner == 0 && !inst_cyc) begin
            m_owner = -1;
        end else if (m_owner == 1 && !data_cyc) begin
            m_owner = -1;
        end
    endtask

    // Called at a falling edge with master inputs already set.
    task automatic step(input logic ack_in);
        ram_ack   = ack_in;
        ram_rdata = $urandom;
        #1 compare_now();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_inst(input logic cyc, input logic stb, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
        inst_cyc = cyc; inst_stb = stb; inst_we = we;
        inst_addr = addr; inst_wdata = wdata; inst_sel = sel;
    endtask

    task automatic set_data(input logic cyc, input logic stb, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
        data_cyc = cyc; data_stb = stb; data_we = we;
        data_addr = addr; data_wdata = wdata; data_sel = sel;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_inst(0, 0, 0, '0, '0, '0);
        set_data(0, 0, 0, '0, '0, '0);
        ram_ack = 1'b0;
        ram_rdata = $urandom;
        m_owner = -1; m_last = 1; m_waited = 0;
        #1 compare_now();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Random master drivers.
    logic        d_cyc [2];
    logic        d_stb [2];
    logic        d_we  [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata [2];
    logic [3:0]  d_sel [2];
    int          d_beats [2];

    task automatic new_beat(input int m);
        d_addr[m]  = {$urandom_range(0, 255), 2'b00};
        d_wdata[m] = $urandom;
        d_sel[m]   = 4'($urandom_range(1, 15));
        d_we[m]    = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before 2ms");
        $fatal(1, "bench timed out");
    end

    initial begin
        e_ack_m[0] = 1'b0; e_ack_m[1] = 1'b0;
        e_err_m[0] = 1'b0; e_err_m[1] = 1'b0;
        do_reset();

        // Single INST read of 0x10.
        set_inst(1, 1, 0, 32'h10, '0, 4'hF);
        step(0);
        check("t1_no_gnt_yet", 64'(s_gnt), 64'(2'b00));
        step(0);
        check("t1_gnt", 64'(s_gnt), 64'(2'b10));
        check("t1_addr", 64'(s_addr), 64'h10);
        step(1);
        check("t1_ack", 64'(s_ack), 64'(2'b10));
        set_inst(0, 0, 0, '0, '0, '0);
        step(0);
        check("t1_held_on_drop", 64'(s_gnt), 64'(2'b10));
        step(0);
        check("t1_idle", 64'(s_gnt), 64'(2'b00));

        // Simultaneous requests from reset.
        do_reset();
        set_inst(1, 1, 0, 32'h100, '0, 4'hF);
        set_data(1, 1, 0, 32'h200, '0, 4'hF);
        step(0);
        step(0);
        check("t2_first_tie", 64'(s_gnt), 64'(2'b10));
        step(1);
        set_inst(0, 0, 0, '0, '0, '0);
        step(0);
        step(0);
        check("t2_dead_cycle", 64'(s_gnt), 64'(2'b00));
        step(0);
        check("t2_data_after", 64'(s_gnt), 64'(2'b01));
        step(1);
        set_data(0, 0, 0, '0, '0, '0);
        set_inst(1, 1, 0, 32'h104, '0, 4'hF);
        step(0);
        set_data(1, 1, 0, 32'h204, '0, 4'hF);
        step(0);
        step(0);
        check("t2_next_tie", 64'(s_gnt), 64'(2'b10));
        set_inst(0, 0, 0, '0, '0, '0);
        set_data(0, 0, 0, '0, '0, '0);
        step(0);
        step(0);

        // DATA locked across 4 beats with a 2-cycle strobe gap.
        set_data(1, 1, 0, 32'h80, '0, 4'hF);
        step(0);
        step(0);
        check("t3_data_gnt", 64'(s_gnt), 64'(2'b01));
        set_inst(1, 1, 0, 32'h1234, 32'h5555_AAAA, 4'h3);
        begin
            logic [5:0] stb_seq;
            stb_seq = 6'b110011;
            for (int i = 0; i < 6; i++) begin
                data_stb  = stb_seq[5-i];
                data_addr = 32'h80 + 32'(4 * i);
                step(stb_seq[5-i]);
                check("t3_locked", 64'(s_gnt), 64'(2'b01));
            end
        end
        set_data(0, 0, 0, '0, '0, '0);
        step(0);
        step(0);
        check("t3_dead_cycle", 64'(s_gnt), 64'(2'b00));
        step(0);
        check("t3_inst_after", 64'(s_gnt), 64'(2'b10));
        check("t3_inst_addr", 64'(s_addr), 64'h1234);
        set_inst(0, 0, 0, '0, '0, '0);
        step(0);
        step(0);

        // Watchdog fires after TO unacked cycles; ack in that cycle wins.
        do_reset();
        set_data(1, 1, 0, 32'h300, '0, 4'hF);
        step(0);
        for (int k = 0; k <= TO; k++) begin
            step(0);
            check("t4_err_timing", 64'(s_err), (k == TO) ? 64'(2'b01) : 64'(2'b00));
        end
        set_data(0, 0, 0, '0, '0, '0);
        step(0);
        check("t4_err_one_cycle", 64'(s_err), 64'(2'b00));
        step(0);
        set_data(1, 1, 0, 32'h304, '0, 4'hF);
        step(0);
        for (int k = 0; k <= TO; k++) begin
            step(k == TO);
            check("t4_err_suppressed", 64'(s_err), 64'(2'b00));
        end
        check("t4_ack_wins", 64'(s_ack), 64'(2'b01));
        set_data(0, 0, 0, '0, '0, '0);
        step(0);
        step(0);

        // Asynchronous reset in the middle of a DATA beat.
        set_data(1, 1, 1, 32'h340, 32'h1111_2222, 4'hF);
        step(0);
        step(0);
        ram_ack = 1'b1;
        #1;
        check("t5_pre_ack", 64'(data_ack), 64'(1'b1));
        #1 rst_n = 1'b0;
        #1;
        check("t5_ram_cyc", 64'(ram_cyc), 64'(1'b0));
        check("t5_data_gnt", 64'(data_gnt), 64'(1'b0));
        check("t5_data_ack", 64'(data_ack), 64'(1'b0));
        do_reset();
        set_inst(1, 1, 0, 32'h400, '0, 4'hF);
        set_data(1, 1, 0, 32'h500, '0, 4'hF);
        step(0);
        step(0);
        check("t5_tie_after_reset", 64'(s_gnt), 64'(2'b10));
        set_inst(0, 0, 0, '0, '0, '0);
        set_data(0, 0, 0, '0, '0, '0);
        step(0);
        step(0);

        // DATA write passthrough.
        set_data(1, 1, 1, 32'h40, 32'hDEAD_BEEF, 4'hF);
        step(0);
        check("t6_idle_ctl", 64'(s_ctl), 64'(7'h0));
        check("t6_idle_wdata", 64'(s_wdata), 64'h0);
        step(0);
        check("t6_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
        check("t6_addr", 64'(s_addr), 64'h40);
        check("t6_ctl", 64'(s_ctl), 64'({4'hF, 1'b1, 1'b1, 1'b1}));
        step(1);
        set_data(0, 0, 0, '0, '0, '0);
        step(0);
        step(0);
        check("t6_release_ctl", 64'(s_ctl), 64'(7'h0));

        // Random two-master traffic.
        do_reset();
        for (int m = 0; m < 2; m++) begin
            d_cyc[m] = 1'b0; d_stb[m] = 1'b0; d_beats[m] = 0;
            new_beat(m);
        end
        e_ack_m[0] = 1'b0; e_ack_m[1] = 1'b0;
        e_err_m[0] = 1'b0; e_err_m[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic ack_now;
            for (int m = 0; m < 2; m++) begin
                if (d_cyc[m]) begin
                    if (e_err_m[m]) begin
                        d_cyc[m] = 1'b0; d_stb[m] = 1'b0;
                    end else if (e_ack_m[m] && d_stb[m]) begin
                        d_beats[m]--;
                        if (d_beats[m] == 0) begin
                            d_cyc[m] = 1'b0; d_stb[m] = 1'b0;
                        end else begin
                            new_beat(m);
                            d_stb[m] = ($urandom_range(0, 3) != 0);
                        end
                    end else if (!d_stb[m]) begin
                        d_stb[m] = 1'($urandom_range(0, 1));
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    d_cyc[m] = 1'b1; d_stb[m] = 1'b1;
                    d_beats[m] = $urandom_range(1, 4);
                    new_beat(m);
                end
            end
            set_inst(d_cyc[0], d_stb[0], d_we[0], d_addr[0], d_wdata[0], d_sel[0]);
            set_data(d_cyc[1], d_stb[1], d_we[1], d_addr[1], d_wdata[1], d_sel[1]);
            if ((m_owner == 0 && inst_stb) || (m_owner == 1 && data_stb))
                ack_now = ($urandom_range(0, 3) == 0);
            else
                ack_now = ($urandom_range(0, 15) == 0);
            step(ack_now);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
